wb_peripheral_bus_bridge: RTL and testbench

Parametrised Wishbone-slave to peripheral-bus bridge; the next generation of the single-access peripheral bus interface. Accepts pipelined Wishbone requests into a request FIFO, issues them one at a time on the peripheral bus, and returns in-order ack/error responses with registered read data. Adds configurable widths, queued requests, captured write data, a busy-timeout error response and cycle-abort flushing.

---
 rtl/wb_peripheral_bus_bridge_if.sv | 49 ++++
 rtl/wb_peripheral_bus_bridge.sv | 173 +++++++++++++++++
 tb/tb_wb_peripheral_bus_bridge.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_peripheral_bus_bridge_if.sv
// Wishbone slave plus peripheral bus signal bundle for the bridge.
// The slave modport is the bridge side; master is the system side.
interface wb_peripheral_bus_bridge_if #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int DATA_WIDTH    = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                     wb_cyc_i;
    logic                     wb_stb_i;
    logic                     wb_we_i;
    logic [SEL_WIDTH-1:0]     wb_sel_i;
    logic [ADDRESS_WIDTH-1:0] wb_adr_i;
    logic [DATA_WIDTH-1:0]    wb_data_i;
    logic                     wb_ack_o;
    logic                     wb_error_o;
    logic                     wb_stall_o;
    logic [DATA_WIDTH-1:0]    wb_data_o;

    logic                     peripheralBus_we;
    logic                     peripheralBus_oe;
    logic                     peripheralBus_busy;
    logic [ADDRESS_WIDTH-1:0] peripheralBus_address;
    logic [SEL_WIDTH-1:0]     peripheralBus_byteSelect;
    logic [DATA_WIDTH-1:0]    peripheralBus_dataRead;
    logic [DATA_WIDTH-1:0]    peripheralBus_dataWrite;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
        input  wb_adr_i, wb_data_i,
        output wb_ack_o, wb_error_o, wb_stall_o, wb_data_o,
        output peripheralBus_we, peripheralBus_oe,
        input  peripheralBus_busy,
        output peripheralBus_address, peripheralBus_byteSelect,
        input  peripheralBus_dataRead,
        output peripheralBus_dataWrite
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
        output wb_adr_i, wb_data_i,
        input  wb_ack_o, wb_error_o, wb_stall_o, wb_data_o,
        input  peripheralBus_we, peripheralBus_oe,
        output peripheralBus_busy,
        input  peripheralBus_address, peripheralBus_byteSelect,
        output peripheralBus_dataRead,
        input  peripheralBus_dataWrite
    );
endinterface

// File: rtl/wb_peripheral_bus_bridge.sv
// Pipelined Wishbone slave to single-access peripheral bus bridge
// with a request FIFO, busy timeout and cycle-abort flushing.
module wb_peripheral_bus_bridge #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                  wb_clk_i,
    input logic                  wb_rst_i,
    wb_peripheral_bus_bridge_if.slave bus
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef struct packed {
        logic                     we;
        logic [SEL_WIDTH-1:0]     sel;
        logic [ADDRESS_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0]    dat;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t                state_q, state_d;
    req_t                  mem_q [FIFO_DEPTH];
    req_t                  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    req_t                  cur_q, cur_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  drop_q, drop_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic stall;
    logic push;
    logic pop;
    logic have_req;
    logic to_hit;
    logic done;
    logic acc;
    req_t head;
    req_t new_req;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign stall    = (count_q == CNT_W'(FIFO_DEPTH));
    assign push     = bus.wb_cyc_i & bus.wb_stb_i & ~stall;
    assign have_req = (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign new_req  = '{we:  bus.wb_we_i,
                        sel: bus.wb_sel_i,
                        adr: bus.wb_adr_i,
                        dat: bus.wb_data_i};

    assign to_hit = (TIMEOUT_CYCLES != 0) && bus.peripheralBus_busy &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign done   = ~bus.peripheralBus_busy | to_hit;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        to_cnt_d = to_cnt_q;
        drop_d   = drop_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (have_req && bus.wb_cyc_i) begin
                    pop      = 1'b1;
                    cur_d    = head;
                    to_cnt_d = '0;
                    drop_d   = 1'b0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.wb_cyc_i) drop_d = 1'b1;
                if (done) begin
                    // Aborted accesses still finish but stay silent.
                    if (bus.wb_cyc_i && !drop_q) begin
                        ack_d = ~bus.peripheralBus_busy;
                        err_d = bus.peripheralBus_busy;
                        if (!bus.peripheralBus_busy && !cur_q.we)
                            rdata_d = bus.peripheralBus_dataRead;
                    end
                    if (have_req && bus.wb_cyc_i) begin
                        pop      = 1'b1;
                        cur_d    = head;
                        to_cnt_d = '0;
                        drop_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!bus.wb_cyc_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_req;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
            to_cnt_q <= '0;
            drop_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cur_q    <= cur_d;
            to_cnt_q <= to_cnt_d;
            drop_q   <= drop_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mem_q    <= mem_d;
        end
    end

    assign acc = (state_q == ACCESS);

    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_error_o = err_q;
    assign bus.wb_stall_o = stall;
    assign bus.wb_data_o  = rdata_q;

    assign bus.peripheralBus_we         = acc & cur_q.we;
    assign bus.peripheralBus_oe         = acc & ~cur_q.we;
    assign bus.peripheralBus_address    = acc ? cur_q.adr : '0;
    assign bus.peripheralBus_byteSelect = acc ? cur_q.sel : '0;
    assign bus.peripheralBus_dataWrite  = (acc && cur_q.we) ? cur_q.dat : '0;
endmodule

// File: tb/tb_wb_peripheral_bus_bridge.sv
// Scoreboard bench for wb_peripheral_bus_bridge (depth 2, timeout 4).
// Responses are popped from an expectation queue as they appear.
module tb_wb_peripheral_bus_bridge;
    localparam int AW = 24;
    localparam int DW = 32;

    typedef struct {
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    bit   stall_seen;

    exp_t        sb[$];
    logic [23:0] issued_q[$];
    int          ack_cyc_q[$];

    always #5 clk = ~clk;

    wb_peripheral_bus_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_peripheral_bus_bridge #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (2),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    function automatic logic [31:0] model_rd(input logic [23:0] a);
        return (a == 24'h000010) ? 32'hDEADBEEF : {8'hC0, a};
    endfunction

    assign bus.peripheralBus_dataRead = model_rd(bus.peripheralBus_address);

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (bus.wb_ack_o || bus.wb_error_o) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected ack=%b err=%b data=%h",
                             bus.wb_ack_o, bus.wb_error_o, bus.wb_data_o);
                end else begin
                    e = sb.pop_front();
                    if (bus.wb_ack_o === bus.wb_error_o ||
                        bus.wb_error_o !== e.err ||
                        bus.wb_data_o !== e.data) begin
                        bad++;
                        $display("FAIL resp ack=%b err=%b data=%h want_err=%b want_data=%h",
                                 bus.wb_ack_o, bus.wb_error_o, bus.wb_data_o,
                                 e.err, e.data);
                    end
                end
                if (bus.wb_ack_o) ack_cyc_q.push_back(cyc_n);
            end
            if ((bus.peripheralBus_oe || bus.peripheralBus_we) &&
                !bus.peripheralBus_busy)
                issued_q.push_back(bus.peripheralBus_address);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [3:0] sel,
                         input logic [23:0] adr, input logic [31:0] dat,
                         input bit want, input bit err);
        int   n;
        exp_t e;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        bus.wb_we_i   = we;
        bus.wb_sel_i  = sel;
        bus.wb_adr_i  = adr;
        bus.wb_data_i = dat;
        n = 0;
        while (bus.wb_stall_o && n < 40) begin
            step();
            n++;
        end
        total++;
        if (bus.wb_stall_o !== 1'b0) begin
            bad++;
            $display("FAIL issue_stall adr=%h stall=%b want=0", adr, bus.wb_stall_o);
        end
        if (want) begin
            e.err  = err;
            e.data = (err || we) ? 32'h0 : model_rd(adr);
            sb.push_back(e);
        end
        step();
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        total += 5;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_error_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_resp ack=%b err=%b want=0", bus.wb_ack_o, bus.wb_error_o);
        end
        if (bus.wb_stall_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_stall got=%b want=0", bus.wb_stall_o);
        end
        if (bus.wb_data_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_data got=%h want=0", bus.wb_data_o);
        end
        if (bus.peripheralBus_we !== 1'b0 || bus.peripheralBus_oe !== 1'b0) begin
            bad++;
            $display("FAIL rst_strobe we=%b oe=%b want=0",
                     bus.peripheralBus_we, bus.peripheralBus_oe);
        end
        if (bus.peripheralBus_address !== 24'h0 ||
            bus.peripheralBus_byteSelect !== 4'h0 ||
            bus.peripheralBus_dataWrite !== 32'h0) begin
            bad++;
            $display("FAIL rst_pbus adr=%h sel=%h wd=%h want=0",
                     bus.peripheralBus_address, bus.peripheralBus_byteSelect,
                     bus.peripheralBus_dataWrite);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        bus.peripheralBus_busy = 1'b0;
        issue(1'b0, 4'hF, 24'h000010, 32'h0, 1'b1, 1'b0);
        total++;
        if (bus.peripheralBus_oe !== 1'b0) begin
            bad++;
            $display("FAIL rd_early oe=%b want=0", bus.peripheralBus_oe);
        end
        step();
        total++;
        if (bus.peripheralBus_oe !== 1'b1 || bus.peripheralBus_we !== 1'b0 ||
            bus.peripheralBus_address !== 24'h000010) begin
            bad++;
            $display("FAIL rd_access oe=%b we=%b adr=%h want oe=1 we=0 adr=000010",
                     bus.peripheralBus_oe, bus.peripheralBus_we,
                     bus.peripheralBus_address);
        end
        step();
        total += 2;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_ack ack=%b data=%h want ack=1 data=deadbeef",
                     bus.wb_ack_o, bus.wb_data_o);
        end
        if (bus.peripheralBus_oe !== 1'b0 || bus.peripheralBus_address !== 24'h0 ||
            bus.peripheralBus_byteSelect !== 4'h0) begin
            bad++;
            $display("FAIL rd_after oe=%b adr=%h sel=%h want=0",
                     bus.peripheralBus_oe, bus.peripheralBus_address,
                     bus.peripheralBus_byteSelect);
        end
        step();
        total++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_data_o !== 32'h0) begin
            bad++;
            $display("FAIL rd_ack_len ack=%b data=%h want=0", bus.wb_ack_o, bus.wb_data_o);
        end
        drain();
    endtask

    task automatic test_write();
        issue(1'b1, 4'h3, 24'h000020, 32'h12345678, 1'b1, 1'b0);
        bus.wb_data_i = 32'h0;
        step();
        total++;
        if (bus.peripheralBus_we !== 1'b1 || bus.peripheralBus_oe !== 1'b0 ||
            bus.peripheralBus_dataWrite !== 32'h12345678 ||
            bus.peripheralBus_byteSelect !== 4'h3 ||
            bus.peripheralBus_address !== 24'h000020) begin
            bad++;
            $display("FAIL wr_access we=%b oe=%b wd=%h sel=%h adr=%h want 1 0 12345678 3 000020",
                     bus.peripheralBus_we, bus.peripheralBus_oe,
                     bus.peripheralBus_dataWrite, bus.peripheralBus_byteSelect,
                     bus.peripheralBus_address);
        end
        step();
        total++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h0) begin
            bad++;
            $display("FAIL wr_ack ack=%b data=%h want ack=1 data=0",
                     bus.wb_ack_o, bus.wb_data_o);
        end
        drain();
    endtask

    task automatic test_pipelined();
        bus.peripheralBus_busy = 1'b1;
        stall_seen = 1'b0;
        issued_q.delete();
        fork
            begin
                issue(1'b0, 4'hF, 24'h000100, 32'h0, 1'b1, 1'b0);
                issue(1'b0, 4'hF, 24'h000104, 32'h0, 1'b1, 1'b0);
                issue(1'b0, 4'hF, 24'h000108, 32'h0, 1'b1, 1'b0);
            end
            begin
                int n = 0;
                while (!bus.peripheralBus_oe && n < 20) begin
                    step();
                    n++;
                end
                repeat (3) step();
                bus.peripheralBus_busy = 1'b0;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (bus.wb_stall_o) stall_seen = 1'b1;
                end
            end
        join
        total++;
        if (stall_seen !== 1'b1) begin
            bad++;
            $display("FAIL pipe_stall seen=%b want=1", stall_seen);
        end
        drain();
        step();
        total++;
        if (issued_q.size() != 3 || issued_q[0] !== 24'h000100 ||
            issued_q[1] !== 24'h000104 || issued_q[2] !== 24'h000108) begin
            bad++;
            $display("FAIL pipe_order n=%0d want 3 accesses 100,104,108", issued_q.size());
        end
    endtask

    task automatic test_timeout();
        bus.peripheralBus_busy = 1'b1;
        issue(1'b0, 4'hF, 24'h000200, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 4'hF, 24'h000204, 32'h0, 1'b1, 1'b0);
        repeat (3) step();
        total++;
        if (bus.wb_error_o !== 1'b0 || bus.wb_ack_o !== 1'b0 ||
            bus.peripheralBus_address !== 24'h000200) begin
            bad++;
            $display("FAIL to_early err=%b ack=%b adr=%h want 0 0 000200",
                     bus.wb_error_o, bus.wb_ack_o, bus.peripheralBus_address);
        end
        step();
        total++;
        if (bus.wb_error_o !== 1'b1 || bus.wb_ack_o !== 1'b0 ||
            bus.wb_data_o !== 32'h0 || bus.peripheralBus_address !== 24'h000204) begin
            bad++;
            $display("FAIL to_err err=%b ack=%b data=%h adr=%h want 1 0 0 000204",
                     bus.wb_error_o, bus.wb_ack_o, bus.wb_data_o,
                     bus.peripheralBus_address);
        end
        bus.peripheralBus_busy = 1'b0;
        step();
        step();
        total++;
        if (bus.peripheralBus_oe !== 1'b0 || bus.wb_error_o !== 1'b0) begin
            bad++;
            $display("FAIL to_after oe=%b err=%b want=0", bus.peripheralBus_oe,
                     bus.wb_error_o);
        end
        drain();
    endtask

    task automatic test_abort();
        bus.peripheralBus_busy = 1'b1;
        issued_q.delete();
        issue(1'b0, 4'hF, 24'h000300, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 4'hF, 24'h000304, 32'h0, 1'b0, 1'b0);
        step();
        bus.wb_cyc_i = 1'b0;
        step();
        bus.peripheralBus_busy = 1'b0;
        step();
        total++;
        if (bus.peripheralBus_oe !== 1'b0 || bus.wb_stall_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle oe=%b stall=%b want=0", bus.peripheralBus_oe,
                     bus.wb_stall_o);
        end
        bus.wb_cyc_i = 1'b1;
        repeat (4) step();
        total += 2;
        if (bus.peripheralBus_oe !== 1'b0 || bus.peripheralBus_we !== 1'b0) begin
            bad++;
            $display("FAIL abort_queued oe=%b we=%b want=0", bus.peripheralBus_oe,
                     bus.peripheralBus_we);
        end
        if (issued_q.size() != 1 || issued_q[0] !== 24'h000300) begin
            bad++;
            $display("FAIL abort_issued n=%0d want 1 access at 000300", issued_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.peripheralBus_busy = 1'b1;
        issue(1'b0, 4'hF, 24'h000400, 32'h0, 1'b0, 1'b0);
        step();
        total++;
        if (bus.peripheralBus_oe !== 1'b1) begin
            bad++;
            $display("FAIL rmid_access oe=%b want=1", bus.peripheralBus_oe);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total += 3;
        if (bus.peripheralBus_oe !== 1'b0 || bus.peripheralBus_we !== 1'b0 ||
            bus.peripheralBus_address !== 24'h0 ||
            bus.peripheralBus_byteSelect !== 4'h0) begin
            bad++;
            $display("FAIL rmid_pbus oe=%b we=%b adr=%h sel=%h want=0",
                     bus.peripheralBus_oe, bus.peripheralBus_we,
                     bus.peripheralBus_address, bus.peripheralBus_byteSelect);
        end
        if (bus.wb_ack_o !== 1'b0 || bus.wb_error_o !== 1'b0 ||
            bus.wb_data_o !== 32'h0) begin
            bad++;
            $display("FAIL rmid_resp ack=%b err=%b data=%h want=0",
                     bus.wb_ack_o, bus.wb_error_o, bus.wb_data_o);
        end
        if (bus.wb_stall_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_stall got=%b want=0", bus.wb_stall_o);
        end
        repeat (6) step();
        bus.peripheralBus_busy = 1'b0;
        issue(1'b0, 4'hF, 24'h000404, 32'h0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        bus.peripheralBus_busy = 1'b0;
        repeat (2) step();
        ack_cyc_q.delete();
        for (int i = 0; i < 4; i++)
            issue(1'b0, 4'hF, 24'h000500 + 24'(4 * i), 32'h0, 1'b1, 1'b0);
        drain();
        step();
        total++;
        if (ack_cyc_q.size() != 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=4", ack_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (ack_cyc_q[i] - ack_cyc_q[i-1] != 1) begin
                    bad++;
                    $display("FAIL b2b_gap idx=%0d gap=%0d want=1", i,
                             ack_cyc_q[i] - ack_cyc_q[i-1]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst                    = 1'b1;
        bus.wb_cyc_i           = 1'b0;
        bus.wb_stb_i           = 1'b0;
        bus.wb_we_i            = 1'b0;
        bus.wb_sel_i           = 4'h0;
        bus.wb_adr_i           = 24'h0;
        bus.wb_data_i          = 32'h0;
        bus.peripheralBus_busy = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_write();
        test_pipelined();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
